// File: rtl/trace_pkg.sv
// Shared definitions for the writeback trace capture path: record layout,
// field offsets and the event qualification rule.
package trace_pkg;

    localparam int TRACE_W  = 73;
    localparam int PC_LSB   = 41;
    localparam int WE_LSB   = 37;
    localparam int WNUM_LSB = 32;

    // One retired register-file write; pc lands in [72:41], wdata in [31:0].
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_rec_t;

    // A write is traced when any byte strobe is set, unless it targets r0
    // and r0 filtering is enabled (r0 writes are architecturally void).
    function automatic logic is_trace_event(input logic [3:0] we,
                                            input logic [4:0] wnum,
                                            input logic       filter_r0);
        return (|we) && !(filter_r0 && (wnum == 5'd0));
    endfunction

endpackage

// File: rtl/wb_trace_fifo_if.sv
// Writeback debug bus in, trace record stream out.
interface wb_trace_fifo_if;
    import trace_pkg::*;

    logic [31:0]        debug_wb_pc;
    logic [3:0]         debug_wb_rf_we;
    logic [4:0]         debug_wb_rf_wnum;
    logic [31:0]        debug_wb_rf_wdata;
    logic               trace_valid;
    logic               trace_ready;
    logic [TRACE_W-1:0] trace_data;

    // Environment side: CPU debug port plus the trace consumer.
    modport master (
        output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        output trace_ready,
        input  trace_valid, trace_data
    );

    // Trace buffer side.
    modport slave (
        input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        input  trace_ready,
        output trace_valid, trace_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with combinational read port. Pointers carry one
// extra MSB so full and empty are told apart without a separate counter.
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int PW = AW + 1;

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wptr == rptr);
    assign full  = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
    assign level = wptr - rptr;

    // A pop only counts when there is a head; a push into a full FIFO is
    // allowed only when the same cycle frees a slot.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    // Head is presented combinationally; forced to zero when nothing is held.
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer update; clear empties the FIFO and beats any push/pop.
    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PW'(1);
            if (rd_en) rptr <= rptr + PW'(1);
        end
    end

    // Storage write.
    // NOTE: the array has no reset; stale slots are unreachable behind the pointers.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/wb_trace_fifo.sv
// Trace capture buffer behind the CPU writeback debug port. Every qualifying
// register-file write becomes one record; when the buffer is full, records
// are dropped and counted instead of stalling the CPU.
module wb_trace_fifo
    import trace_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int FILTER_R0 = 1,
    parameter  int CNT_W     = 16,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    wb_trace_fifo_if.slave   bus,
    input  logic             clear,
    output logic [LW-1:0]    trace_level,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             overflow
);

    trace_rec_t rec;
    logic       ev;
    logic       pop;
    logic       push;
    logic       drop;
    logic       full;
    logic       empty;

    assign rec.pc    = bus.debug_wb_pc;
    assign rec.we    = bus.debug_wb_rf_we;
    assign rec.wnum  = bus.debug_wb_rf_wnum;
    assign rec.wdata = bus.debug_wb_rf_wdata;

    assign bus.trace_valid = ~empty;
    assign pop             = bus.trace_valid & bus.trace_ready;

    // Classify this cycle's event as stored, dropped, or discarded by clear.
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    always_comb begin
        ev   = is_trace_event(bus.debug_wb_rf_we, bus.debug_wb_rf_wnum, FILTER_R0 != 0);
        push = 1'b0;
        drop = 1'b0;
        if (ev && !clear) begin
            if (!full || pop) push = 1'b1;
            else              drop = 1'b1;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRACE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (rec),
        .rdata (bus.trace_data),
        .full  (full),
        .empty (empty),
        .level (trace_level)
    );

    // Loss accounting: saturating drop count, wrapping retire count, sticky flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt   <= '0;
            retire_cnt <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            drop_cnt   <= '0;
            retire_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) retire_cnt <= retire_cnt + CNT_W'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_wb_trace_fifo;
    import trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic [LW-1:0]    trace_level;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic             overflow;

    wb_trace_fifo_if bus();

    wb_trace_fifo #(
        .DEPTH     (DEPTH),
        .FILTER_R0 (1),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .clear       (clear),
        .trace_level (trace_level),
        .drop_cnt    (drop_cnt),
        .retire_cnt  (retire_cnt),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: records held, plus the three status values.
    logic [72:0] mq[$];
    int          m_drop   = 0;
    int          m_retire = 0;
    bit          m_ovf    = 1'b0;

    function automatic logic [72:0] mk(input logic [31:0] pc, input logic [3:0] we,
                                       input logic [4:0] wnum, input logic [31:0] wdata);
        return {pc, we, wnum, wdata};
    endfunction

    function automatic logic [72:0] exp_head();
        return (mq.size() != 0) ? mq[0] : 73'd0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_drop   = 0;
        m_retire = 0;
        m_ovf    = 1'b0;
    endtask

    // One clock edge worth of FIFO rules, applied to the inputs presented.
    task automatic model_step();
        bit ev;
        bit pop;
        int sz;
        if (reset) begin
            model_reset();
            return;
        end
        ev  = (bus.debug_wb_rf_we != 4'd0) && (bus.debug_wb_rf_wnum != 5'd0);
        pop = (mq.size() != 0) && bus.trace_ready;
        if (clear) begin
            model_reset();
            return;
        end
        sz = mq.size();
        if (pop) void'(mq.pop_front());
        if (ev) begin
            if (sz < DEPTH || pop) begin
                mq.push_back(mk(bus.debug_wb_pc, bus.debug_wb_rf_we,
                                bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata));
                m_retire = (m_retire + 1) % (1 << CNT_W);
            end else begin
                if (m_drop < (1 << CNT_W) - 1) m_drop++;
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wnum,
                         input logic [31:0] wdata, input logic rdy);
        bus.debug_wb_pc       = pc;
        bus.debug_wb_rf_we    = we;
        bus.debug_wb_rf_wnum  = wnum;
        bus.debug_wb_rf_wdata = wdata;
        bus.trace_ready       = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(32'h0, 4'h0, 5'd0, 32'h0, rdy);
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_clear();
        idle(1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear = 1'b0;
        idle(1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.trace_valid); end
        n_checks++; if (bus.trace_data !== 73'd0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", bus.trace_data); end
        n_checks++; if (trace_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", trace_level); end
        n_checks++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        n_checks++; if (retire_cnt !== '0) begin n_fail++; $display("FAIL reset_retire: got %0d want 0", retire_cnt); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_write_filter();
        logic [72:0] want;
        logic [31:0] wd;
        for (int i = 0; i < 3; i++) begin
            wd = $urandom;
            drive(32'h1c00_0000 + 32'(4 * i), 4'hF, 5'(i + 1), wd, 1'b1);
            tick();
            want = mk(32'h1c00_0000 + 32'(4 * i), 4'hF, 5'(i + 1), wd);
            n_checks++; if (bus.trace_valid !== 1'b1) begin n_fail++; $display("FAIL wf_valid[%0d]: got %0b want 1", i, bus.trace_valid); end
            n_checks++; if (bus.trace_data !== want) begin n_fail++; $display("FAIL wf_data[%0d]: got %0h want %0h", i, bus.trace_data, want); end
        end
        idle(1'b1);
        tick();
        n_checks++; if (retire_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL wf_retire: got %0d want 3", retire_cnt); end
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL wf_drained: got %0b want 0", bus.trace_valid); end
        drive(32'h1c00_000c, 4'h0, 5'd5, 32'hdead_beef, 1'b1);
        tick();
        n_checks++; if (bus.trace_valid !== 1'b0 || retire_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL wf_we0: valid %0b retire %0d want 0/3", bus.trace_valid, retire_cnt); end
        drive(32'h1c00_0010, 4'hF, 5'd0, 32'hcafe_f00d, 1'b1);
        tick();
        n_checks++; if (bus.trace_valid !== 1'b0 || retire_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL wf_r0: valid %0b retire %0d want 0/3", bus.trace_valid, retire_cnt); end
        idle(1'b0);
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 20; i++) begin
            drive(32'h1c00_0100 + 32'(4 * i), 4'hF, 5'd7, 32'(i), 1'b0);
            tick();
        end
        idle(1'b0);
        n_checks++; if (trace_level !== LW'(16)) begin n_fail++; $display("FAIL ov_level: got %0d want 16", trace_level); end
        n_checks++; if (drop_cnt !== CNT_W'(4)) begin n_fail++; $display("FAIL ov_drop: got %0d want 4", drop_cnt); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ov_flag: got %0b want 1", overflow); end
        n_checks++; if (retire_cnt !== CNT_W'(16)) begin n_fail++; $display("FAIL ov_retire: got %0d want 16", retire_cnt); end
        n_checks++; if (bus.trace_data[72:41] !== 32'h1c00_0100) begin n_fail++; $display("FAIL ov_head_pc: got %0h want 1c000100", bus.trace_data[72:41]); end
    endtask

    // Runs on the full FIFO left by test_overflow, then drains it.
    task automatic test_full_push_pop();
        logic [31:0] want_pc;
        drive(32'h1c00_0200, 4'h3, 5'd9, 32'h1234_5678, 1'b1);
        tick();
        idle(1'b1);
        n_checks++; if (trace_level !== LW'(16)) begin n_fail++; $display("FAIL fpp_level: got %0d want 16", trace_level); end
        n_checks++; if (drop_cnt !== CNT_W'(4)) begin n_fail++; $display("FAIL fpp_drop: got %0d want 4", drop_cnt); end
        for (int i = 0; i < 16; i++) begin
            want_pc = (i < 15) ? 32'h1c00_0104 + 32'(4 * i) : 32'h1c00_0200;
            n_checks++; if (bus.trace_data[72:41] !== want_pc || bus.trace_data !== exp_head()) begin
                n_fail++; $display("FAIL fpp_drain[%0d]: got %0h want pc %0h rec %0h", i, bus.trace_data, want_pc, exp_head());
            end
            tick();
        end
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %0b want 0", bus.trace_valid); end
    endtask

    task automatic test_backpressure();
        logic [72:0] held;
        do_clear();
        drive(32'h1c00_0300, 4'hF, 5'd4, 32'h0bad_0001, 1'b0);
        tick();
        held = bus.trace_data;
        n_checks++; if (trace_level !== LW'(1) || held !== exp_head()) begin n_fail++; $display("FAIL bp_first: level %0d data %0h want 1 %0h", trace_level, held, exp_head()); end
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(32'h1c00_0304 + 32'(4 * c), 4'hF, 5'd4, 32'(c), 1'b0);
            else       idle(1'b0);
            tick();
            n_checks++; if (bus.trace_data !== held) begin n_fail++; $display("FAIL bp_hold[%0d]: got %0h want %0h", c, bus.trace_data, held); end
            n_checks++; if (trace_level !== LW'((c < 3) ? c + 2 : 4)) begin n_fail++; $display("FAIL bp_level[%0d]: got %0d want %0d", c, trace_level, (c < 3) ? c + 2 : 4); end
        end
    endtask

    task automatic fill_and_drain(input int writes, input int pops);
        do_clear();
        for (int i = 0; i < writes; i++) begin
            drive(32'h1c00_0400 + 32'(4 * i), 4'hF, 5'd3, $urandom, 1'b0);
            tick();
        end
        idle(1'b1);
        repeat (pops) tick();
        idle(1'b0);
    endtask

    task automatic test_clear();
        fill_and_drain(18, 11);
        n_checks++; if (trace_level !== LW'(5) || drop_cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL clr_setup: level %0d drop %0d want 5/2", trace_level, drop_cnt); end
        drive(32'h1c00_0500, 4'hF, 5'd6, 32'h1111_2222, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle(1'b0);
        n_checks++; if (trace_level !== '0) begin n_fail++; $display("FAIL clr_level: got %0d want 0", trace_level); end
        n_checks++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL clr_drop: got %0d want 0", drop_cnt); end
        n_checks++; if (retire_cnt !== '0) begin n_fail++; $display("FAIL clr_retire: got %0d want 0", retire_cnt); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %0b want 0", overflow); end
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %0b want 0", bus.trace_valid); end
    endtask

    task automatic test_async_reset();
        logic [72:0] want;
        fill_and_drain(25, 9);
        n_checks++; if (trace_level !== LW'(7) || drop_cnt !== CNT_W'(9)) begin n_fail++; $display("FAIL ar_setup: level %0d drop %0d want 7/9", trace_level, drop_cnt); end
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_checks++; if (bus.trace_valid !== 1'b0 || bus.trace_data !== 73'd0) begin n_fail++; $display("FAIL ar_stream: valid %0b data %0h want 0/0", bus.trace_valid, bus.trace_data); end
        n_checks++; if (trace_level !== '0 || drop_cnt !== '0) begin n_fail++; $display("FAIL ar_level_drop: %0d/%0d want 0/0", trace_level, drop_cnt); end
        n_checks++; if (retire_cnt !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL ar_retire_ovf: %0d/%0b want 0/0", retire_cnt, overflow); end
        @(negedge clk);
        reset = 1'b0;
        drive(32'h1c00_0600, 4'hC, 5'd31, 32'h5555_aaaa, 1'b0);
        tick();
        idle(1'b0);
        want = mk(32'h1c00_0600, 4'hC, 5'd31, 32'h5555_aaaa);
        n_checks++; if (trace_level !== LW'(1) || retire_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL ar_resume_cnt: level %0d retire %0d want 1/1", trace_level, retire_cnt); end
        n_checks++; if (bus.trace_data !== want) begin n_fail++; $display("FAIL ar_resume_data: got %0h want %0h", bus.trace_data, want); end
    endtask

    task automatic test_random();
        logic [3:0] we;
        logic       rdy;
        do_clear();
        for (int i = 0; i < 600; i++) begin
            we  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            rdy = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive($urandom, we, 5'($urandom), $urandom, rdy);
            clear = ($urandom_range(0, 199) == 0);
            tick();
            n_checks++; if (bus.trace_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, bus.trace_valid, mq.size() != 0); end
            n_checks++; if (bus.trace_data !== exp_head()) begin n_fail++; $display("FAIL rnd_data@%0d: got %0h want %0h", i, bus.trace_data, exp_head()); end
            n_checks++; if (trace_level !== LW'(mq.size())) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d want %0d", i, trace_level, mq.size()); end
            n_checks++; if (drop_cnt !== CNT_W'(m_drop)) begin n_fail++; $display("FAIL rnd_drop@%0d: got %0d want %0d", i, drop_cnt, m_drop); end
            n_checks++; if (retire_cnt !== CNT_W'(m_retire)) begin n_fail++; $display("FAIL rnd_retire@%0d: got %0d want %0d", i, retire_cnt, m_retire); end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow@%0d: got %0b want %0b", i, overflow, m_ovf); end
        end
        clear = 1'b0;
        idle(1'b0);
    endtask

    initial begin
        test_reset();
        test_write_filter();
        test_overflow();
        test_full_push_pop();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
